// File: rtl/lfsr_checker.sv
// Receive-side checker for the soma XNOR LFSR word stream: predicts each next
// word, acquires and holds lock, flywheels over isolated errors, counts mismatches.
module lfsr_checker #(
  parameter int NUM_BITS = 20,
  parameter int LOCK_RUN = 8,
  parameter int LOSS_RUN = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic                i_valid,
  input  logic [NUM_BITS-1:0] i_data,
  output logic                o_locked,
  output logic                o_err,
  output logic [CNT_W-1:0]    o_err_cnt,
  output logic                o_stuck
);

  // Tap masks as 0-indexed bit sets of the 1-indexed polynomial taps.
  localparam logic [31:0] TAP_MASK32 =
      (NUM_BITS == 16) ? 32'h0000_D008 :
      (NUM_BITS == 20) ? 32'h0009_0000 :
      (NUM_BITS == 24) ? 32'h00E1_0000 :
      (NUM_BITS == 32) ? 32'h8020_0003 : 32'h0000_0000;

  generate
    if (NUM_BITS != 16 && NUM_BITS != 20 && NUM_BITS != 24 && NUM_BITS != 32) begin : g_bad_width
      $error("lfsr_checker: unsupported NUM_BITS %0d", NUM_BITS);
    end
  endgenerate

  localparam logic [NUM_BITS-1:0] TAP_MASK = TAP_MASK32[NUM_BITS-1:0];
  localparam int RUN_W  = $clog2(LOCK_RUN + 1);
  localparam int MISS_W = $clog2(LOSS_RUN + 1);

  typedef enum logic {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t              r_state;
  logic [NUM_BITS-1:0] r_exp;
  logic                r_have_prev;
  logic [RUN_W-1:0]    r_run;
  logic [MISS_W-1:0]   r_miss;
  logic                r_err;
  logic [CNT_W-1:0]    r_err_cnt;
  logic                r_stuck;

  logic [NUM_BITS-1:0] w_next_data;
  logic [NUM_BITS-1:0] w_next_exp;
  logic                w_match;
  logic                w_all_ones;

  // Shift left with the XNOR of the taps entering at the LSB.
  assign w_next_data = {i_data[NUM_BITS-2:0], ~(^(i_data & TAP_MASK))};
  assign w_next_exp  = {r_exp[NUM_BITS-2:0],  ~(^(r_exp  & TAP_MASK))};
  assign w_match     = (i_data == r_exp);
  assign w_all_ones  = &i_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_HUNT;
      r_exp       <= '0;
      r_have_prev <= 1'b0;
      r_run       <= '0;
      r_miss      <= '0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
      r_stuck     <= 1'b0;
    end else if (i_clear) begin
      r_state     <= S_HUNT;
      r_have_prev <= 1'b0;
      r_run       <= '0;
      r_miss      <= '0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
      r_stuck     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (i_valid) begin
        r_stuck <= w_all_ones;
        case (r_state)
          S_HUNT: begin
            r_exp       <= w_next_data;
            r_have_prev <= 1'b1;
            // The all-ones lock-up word predicts itself, so it never builds a run.
            if (r_have_prev && w_match && !w_all_ones) begin
              if (r_run == RUN_W'(LOCK_RUN - 1)) begin
                r_state <= S_LOCKED;
                r_run   <= '0;
                r_miss  <= '0;
              end else begin
                r_run <= r_run + RUN_W'(1);
              end
            end else begin
              r_run <= '0;
            end
          end
          S_LOCKED: begin
            if (w_match) begin
              r_exp  <= w_next_data;
              r_miss <= '0;
            end else begin
              r_err <= 1'b1;
              if (r_err_cnt != {CNT_W{1'b1}})
                r_err_cnt <= r_err_cnt + CNT_W'(1);
              // Flywheel on the prediction so a corrupt word cannot resync us.
              r_exp <= w_next_exp;
              if (r_miss == MISS_W'(LOSS_RUN - 1)) begin
                r_state     <= S_HUNT;
                r_run       <= '0;
                r_miss      <= '0;
                r_have_prev <= 1'b0;
              end else begin
                r_miss <= r_miss + MISS_W'(1);
              end
            end
          end
          default: r_state <= S_HUNT;
        endcase
      end
    end
  end

  assign o_locked  = (r_state == S_LOCKED);
  assign o_err     = r_err;
  assign o_err_cnt = r_err_cnt;
  assign o_stuck   = r_stuck;

endmodule
